// File: rtl/or_pkg.sv
// Shared constants and types for the bitwise OR unit.
package or_pkg;

    localparam int OR_WIDTH = 4;

    typedef logic [OR_WIDTH-1:0] word_t;

endpackage : or_pkg

// File: rtl/or_4b_reg_if.sv
// Operand, control and result bundle for or_4b_reg; master drives operands, slave is the OR unit.
interface or_4b_reg_if #(
    parameter int WIDTH = or_pkg::OR_WIDTH
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] out;
    logic             in_valid;
    logic             acc_en;
    logic             clear;
    logic [WIDTH-1:0] out_q;
    logic             out_valid;
    logic             any_set;

    modport master (
        output x, y, in_valid, acc_en, clear,
        input  out, out_q, out_valid, any_set
    );

    modport slave (
        input  x, y, in_valid, acc_en, clear,
        output out, out_q, out_valid, any_set
    );

endinterface : or_4b_reg_if

// File: rtl/or_bitwise.sv
// Pure combinational WIDTH-bit OR; bits never mix across positions.
module or_bitwise #(
    parameter int WIDTH = or_pkg::OR_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a | b;

endmodule : or_bitwise

// File: rtl/or_4b_reg.sv
// Bitwise OR unit: combinational x | y plus a registered, optionally accumulating copy.
module or_4b_reg
    import or_pkg::*;
#(
    parameter int WIDTH = OR_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    or_4b_reg_if.slave  bus
);

    logic [WIDTH-1:0] or_xy;
    logic [WIDTH-1:0] or_acc;
    logic [WIDTH-1:0] out_q_d;
    logic [WIDTH-1:0] out_q_q;
    logic             out_valid_d;
    logic             out_valid_q;

    or_bitwise #(.WIDTH(WIDTH)) u_or_comb (
        .a (bus.x),
        .b (bus.y),
        .y (or_xy)
    );

    // Accumulation merges the fresh operands with the held value; saturates naturally at all ones.
    or_bitwise #(.WIDTH(WIDTH)) u_or_acc (
        .a (or_xy),
        .b (out_q_q),
        .y (or_acc)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        out_q_d     = out_q_q;
        out_valid_d = 1'b0;
        if (bus.clear) begin
            out_q_d     = '0;
            out_valid_d = 1'b0;
        end else if (bus.in_valid) begin
            out_q_d     = bus.acc_en ? or_acc : or_xy;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = or_xy;
    assign bus.out_q     = out_q_q;
    assign bus.out_valid = out_valid_q;
    assign bus.any_set   = |out_q_q;

endmodule : or_4b_reg

// File: tb/tb_or_4b_reg.sv
// Self-checking bench for or_4b_reg: directed vector table plus hand-written corner sequences.
module tb_or_4b_reg;
    import or_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    or_4b_reg_if #(.WIDTH(4)) bus4 ();
    or_4b_reg_if #(.WIDTH(1)) bus1 ();
    or_4b_reg_if #(.WIDTH(8)) bus8 ();

    or_4b_reg #(.WIDTH(4)) dut  (.clk(clk), .rst(rst), .bus(bus4));
    or_4b_reg #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    or_4b_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        word_t x;
        word_t y;
        logic  iv;
        logic  acc;
        logic  clr;
        word_t e_out;
        word_t e_q;
        logic  e_v;
        logic  e_any;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive4(input word_t x, input word_t y, input logic iv, input logic acc,
                          input logic clr);
        bus4.x        = x;
        bus4.y        = y;
        bus4.in_valid = iv;
        bus4.acc_en   = acc;
        bus4.clear    = clr;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //            x        y        iv    acc   clr   e_out    e_q      e_v   e_any
        vecs[0]  = '{4'b0101, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0111, 4'b0111, 1'b1, 1'b1};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0111, 1'b0, 1'b1};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1};
        vecs[4]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0100, 4'b0101, 1'b1, 1'b1};
        vecs[5]  = '{4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b1101, 1'b1, 1'b1};
        vecs[6]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0};
        vecs[7]  = '{4'b1010, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b1110, 4'b1110, 1'b1, 1'b1};
        vecs[8]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b1111, 1'b1, 1'b1};
        vecs[9]  = '{4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 4'b1111, 1'b1, 1'b1};
        vecs[10] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vecs[11] = '{4'b1100, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b1101, 4'b1101, 1'b1, 1'b1};

        drive4(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        bus1.x = 1'b0; bus1.y = 1'b0; bus1.in_valid = 1'b0; bus1.acc_en = 1'b0; bus1.clear = 1'b0;
        bus8.x = '0;   bus8.y = '0;   bus8.in_valid = 1'b0; bus8.acc_en = 1'b0; bus8.clear = 1'b0;
        rst = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset out_q", 32'(bus4.out_q), 32'h0);
        check("reset out_valid", 32'(bus4.out_valid), 32'h0);
        check("reset any_set", 32'(bus4.any_set), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Combinational sequence between clock edges, in_valid low
        @(negedge clk);
        bus4.x = 4'b1000; #1 check("comb x=1000", 32'(bus4.out), 32'b1000);
        bus4.y = 4'b1001; #1 check("comb y=1001", 32'(bus4.out), 32'b1001);
        bus4.x = 4'b1101; #1 check("comb x=1101", 32'(bus4.out), 32'b1101);
        bus4.y = 4'b0110; #1 check("comb y=0110", 32'(bus4.out), 32'b1111);
        check("comb no capture", 32'(bus4.out_valid), 32'h0);

        // Table-driven registered behaviour: drive on negedge, check just after posedge
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive4(vecs[i].x, vecs[i].y, vecs[i].iv, vecs[i].acc, vecs[i].clr);
            #1;
            check($sformatf("vec%0d out", i), 32'(bus4.out), 32'(vecs[i].e_out));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_q", i), 32'(bus4.out_q), 32'(vecs[i].e_q));
            check($sformatf("vec%0d out_valid", i), 32'(bus4.out_valid), 32'(vecs[i].e_v));
            check($sformatf("vec%0d any_set", i), 32'(bus4.any_set), 32'(vecs[i].e_any));
        end

        // Async reset between edges with out_q = 1101 and out_valid = 1
        @(negedge clk);
        bus4.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async rst out_q", 32'(bus4.out_q), 32'h0);
        check("async rst out_valid", 32'(bus4.out_valid), 32'h0);
        check("async rst any_set", 32'(bus4.any_set), 32'h0);
        check("async rst out", 32'(bus4.out), 32'b1101);
        rst = 1'b0;

        // rst held across an edge discards that cycle's capture
        @(negedge clk);
        drive4(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst edge out_q", 32'(bus4.out_q), 32'h0);
        check("rst edge out_valid", 32'(bus4.out_valid), 32'h0);
        check("rst edge out", 32'(bus4.out), 32'hF);
        @(negedge clk);
        rst = 1'b0;

        // Capture resumes after reset release
        @(posedge clk);
        #1;
        check("post rst out_q", 32'(bus4.out_q), 32'hF);
        check("post rst out_valid", 32'(bus4.out_valid), 32'h1);

        // Width variants
        @(negedge clk);
        bus8.x = 8'b1010_0000;
        bus8.y = 8'b0000_0101;
        bus1.x = 1'b1;
        bus1.y = 1'b0;
        #1;
        check("w8 out", 32'(bus8.out), 32'b1010_0101);
        check("w1 out 1|0", 32'(bus1.out), 32'h1);
        bus1.x = 1'b0;
        #1;
        check("w1 out 0|0", 32'(bus1.out), 32'h0);
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("w8 out_q", 32'(bus8.out_q), 32'b1010_0101);
        check("w8 any_set", 32'(bus8.any_set), 32'h1);
        check("w1 out_q idle", 32'(bus1.out_q), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_or_4b_reg
